// File: rtl/sat_slice_pipe.sv
// rtl/sat_slice_pipe.sv - pipelined multi-channel saturating bit-field slicer, 2-cycle latency
// Define SAT_SLICE_ROUND_EN for round half-up ahead of saturation; otherwise truncation.
module sat_slice_pipe #(
  parameter int WIN = 64,
  parameter int MSB = 31,
  parameter int LSB = 18,
  parameter int NCH = 2,
  parameter int CW  = 16
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic [NCH*WIN-1:0]               sig_i,
  input  logic                             valid_i,
  input  logic                             clr_i,
  output logic [NCH*(MSB-LSB+1)-1:0]       sig_o,
  output logic                             valid_o,
  output logic [NCH-1:0]                   ovf_o,
  output logic [NCH*CW-1:0]                ovf_cnt_o
);

  localparam int WOUT = MSB - LSB + 1;

`ifdef SAT_SLICE_ROUND_EN
  localparam logic [WIN:0] RND = (LSB >= 1) ?
      ({{WIN{1'b0}}, 1'b1} << ((LSB >= 1) ? (LSB - 1) : 0)) : '0;
`endif

  logic v1_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v1_q    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      v1_q    <= valid_i;
      valid_o <= v1_q;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [WIN-1:0]  s;
    logic [WIN:0]    x_d;
    logic [WIN:0]    x_q;
    logic [WIN-MSB:0] top;
    logic            in_range;
    logic [WOUT-1:0] sat_d;
    logic [WOUT-1:0] res_q;
    logic            ovf_q;
    logic [CW-1:0]   cnt_q;

    assign s = sig_i[k*WIN +: WIN];

    // WIN+1 bits leave room for the rounding carry so it saturates instead of wrapping
`ifdef SAT_SLICE_ROUND_EN
    assign x_d = {s[WIN-1], s} + RND;
`else
    assign x_d = {s[WIN-1], s};
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        x_q <= '0;
      end else if (valid_i) begin
        x_q <= x_d;
      end
    end

    assign top      = x_q[WIN:MSB];
    assign in_range = (&top) | ~(|top);

    always_comb begin
      sat_d = x_q[MSB:LSB];
      if (!in_range) begin
        sat_d = x_q[WIN] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        res_q <= '0;
        ovf_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        if (v1_q) begin
          res_q <= sat_d;
          ovf_q <= ~in_range;
        end
        // clear takes priority over a same-cycle overflow event
        if (clr_i) begin
          cnt_q <= '0;
        end else if (v1_q && !in_range && (cnt_q != {CW{1'b1}})) begin
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end

    if (LSB > 0) begin : g_lsb
      logic lsb_unused;
      assign lsb_unused = ^x_q[LSB-1:0];
    end

    assign sig_o[k*WOUT +: WOUT]  = res_q;
    assign ovf_o[k]               = ovf_q;
    assign ovf_cnt_o[k*CW +: CW]  = cnt_q;
  end

endmodule

// File: tb/tb_sat_slice_pipe.sv
// tb/tb_sat_slice_pipe.sv - directed table and streaming bench for sat_slice_pipe (CW=4)
module tb_sat_slice_pipe;

  localparam int WIN  = 64;
  localparam int MSB  = 31;
  localparam int LSB  = 18;
  localparam int NCH  = 2;
  localparam int CW   = 4;
  localparam int WOUT = 14;

  logic                 clk = 1'b0;
  logic                 rstn_i;
  logic [NCH*WIN-1:0]   sig_i;
  logic                 valid_i;
  logic                 clr_i;
  logic [NCH*WOUT-1:0]  sig_o;
  logic                 valid_o;
  logic [NCH-1:0]       ovf_o;
  logic [NCH*CW-1:0]    ovf_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sat_slice_pipe #(.WIN(WIN), .MSB(MSB), .LSB(LSB), .NCH(NCH), .CW(CW)) dut (
    .clk_i     (clk),
    .rstn_i    (rstn_i),
    .sig_i     (sig_i),
    .valid_i   (valid_i),
    .clr_i     (clr_i),
    .sig_o     (sig_o),
    .valid_o   (valid_o),
    .ovf_o     (ovf_o),
    .ovf_cnt_o (ovf_cnt_o)
  );

  // reference state: 2-deep pipeline with held outputs
  logic            m_v1;
  logic [63:0]     m_s [NCH];
  logic            m_valid;
  logic [13:0]     m_res [NCH];
  logic            m_ovf [NCH];
  logic [CW-1:0]   m_cnt [NCH];

  typedef struct {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [13:0] e0;
    logic [13:0] e1;
    logic [1:0]  eo;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] ref_sat(input logic [63:0] w);
    logic signed [64:0] v;
    logic signed [64:0] q;
    v = $signed({w[63], w});
`ifdef SAT_SLICE_ROUND_EN
    v = v + 65'sd131072;
`endif
    q = v >>> LSB;
    if (q > 65'sd8191)       ref_sat = {1'b1, 14'h1FFF};
    else if (q < -65'sd8192) ref_sat = {1'b1, 14'h2000};
    else                     ref_sat = {1'b0, q[13:0]};
  endfunction

  task automatic model_reset();
    m_v1    = 1'b0;
    m_valid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_s[c]   = '0;
      m_res[c] = '0;
      m_ovf[c] = 1'b0;
      m_cnt[c] = '0;
    end
  endtask

  task automatic step(input logic v, input logic [63:0] s0, input logic [63:0] s1, input logic clr);
    logic [14:0] r;
    valid_i = v;
    sig_i   = {s1, s0};
    clr_i   = clr;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      r = ref_sat(m_s[c]);
      if (clr) m_cnt[c] = '0;
      else if (m_v1 && r[14] && m_cnt[c] != {CW{1'b1}}) m_cnt[c] = m_cnt[c] + 1'b1;
      if (m_v1) begin
        m_res[c] = r[13:0];
        m_ovf[c] = r[14];
      end
    end
    m_valid = m_v1;
    m_v1    = v;
    if (v) begin
      m_s[0] = s0;
      m_s[1] = s1;
    end
    check("valid_o", {63'd0, valid_o}, {63'd0, m_valid});
    check("sig_o", {36'd0, sig_o}, {36'd0, m_res[1], m_res[0]});
    check("ovf_o", {62'd0, ovf_o}, {62'd0, m_ovf[1], m_ovf[0]});
    check("ovf_cnt_o", {56'd0, ovf_cnt_o}, {56'd0, m_cnt[1], m_cnt[0]});
  endtask

  initial begin
    logic [63:0] rs [NCH];
    logic [31:0] r;
    int n;
    int guard;
    logic v;

    vecs[0] = '{64'h0000_0000_0004_0000, 64'h0, 14'h0001, 14'h0000, 2'b00};
    vecs[1] = '{64'h0000_0001_0000_0000, 64'hFFFF_FFFE_0000_0000, 14'h1FFF, 14'h2000, 2'b11};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 14'h1FFF, 14'h2000, 2'b11};
`ifdef SAT_SLICE_ROUND_EN
    vecs[2] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_7FFF_FFFF, 14'h2000, 14'h1FFF, 2'b10};
    vecs[3] = '{64'h0000_0000_0002_0000, 64'hFFFF_FFFF_FFFE_0000, 14'h0001, 14'h0000, 2'b00};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_7FFC_0000, 14'h0000, 14'h1FFF, 2'b00};
`else
    vecs[2] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_7FFF_FFFF, 14'h2000, 14'h1FFF, 2'b00};
    vecs[3] = '{64'h0000_0000_0002_0000, 64'hFFFF_FFFF_FFFE_0000, 14'h0000, 14'h3FFF, 2'b00};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_7FFC_0000, 14'h3FFF, 14'h1FFF, 2'b00};
`endif

    rstn_i  = 1'b0;
    valid_i = 1'b0;
    sig_i   = '0;
    clr_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset valid_o", {63'd0, valid_o}, 64'd0);
    check("reset sig_o", {36'd0, sig_o}, 64'd0);
    check("reset ovf_o", {62'd0, ovf_o}, 64'd0);
    check("reset ovf_cnt_o", {56'd0, ovf_cnt_o}, 64'd0);
    rstn_i = 1'b1;

    for (int i = 0; i < 6; i++) begin
      step(1'b1, vecs[i].s0, vecs[i].s1, 1'b0);
      check($sformatf("vec%0d early valid", i), {63'd0, valid_o}, 64'd0);
      step(1'b0, 64'd0, 64'd0, 1'b0);
      check($sformatf("vec%0d valid", i), {63'd0, valid_o}, 64'd1);
      check($sformatf("vec%0d ch0", i), {50'd0, sig_o[13:0]}, {50'd0, vecs[i].e0});
      check($sformatf("vec%0d ch1", i), {50'd0, sig_o[27:14]}, {50'd0, vecs[i].e1});
      check($sformatf("vec%0d ovf", i), {62'd0, ovf_o}, {62'd0, vecs[i].eo});
    end

    // counter saturation at 4'hF
    step(1'b0, 64'd0, 64'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 64'h0000_0001_0000_0000, 64'd0, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b0);
    check("cnt0 saturated", {60'd0, ovf_cnt_o[3:0]}, 64'hF);
    check("cnt1 idle", {60'd0, ovf_cnt_o[7:4]}, 64'h0);

    // clear coinciding with an overflow increment
    step(1'b1, 64'h0000_0001_0000_0000, 64'd0, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b1);
    check("clr wins cnt0", {60'd0, ovf_cnt_o[3:0]}, 64'h0);
    check("clr wins ovf0", {63'd0, ovf_o[0]}, 64'd1);
    step(1'b0, 64'd0, 64'd0, 1'b0);
    check("clr hold cnt0", {60'd0, ovf_cnt_o[3:0]}, 64'h0);

    // random stream with gaps
    n = 0;
    guard = 0;
    while (n < 100 && guard < 1000) begin
      v = ($urandom_range(3) != 0);
      for (int c = 0; c < NCH; c++) begin
        r = $urandom;
        case ($urandom_range(2))
          0: rs[c] = {$urandom, $urandom};
          1: rs[c] = {{32{r[31]}}, r};
          default: rs[c] = {{31{r[31]}}, r, 1'b0};
        endcase
      end
      step(v, rs[0], rs[1], 1'b0);
      if (v) n++;
      guard++;
    end
    check("stream sample count", 64'(n), 64'd100);
    step(1'b0, 64'd0, 64'd0, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b0);

    // asynchronous reset between edges while the stream is busy
    step(1'b1, 64'h0000_0001_0000_0000, 64'hFFFF_FFFE_0000_0000, 1'b0);
    step(1'b1, 64'h0000_0001_0000_0000, 64'hFFFF_FFFE_0000_0000, 1'b0);
    step(1'b1, 64'h0000_0001_0000_0000, 64'hFFFF_FFFE_0000_0000, 1'b0);
    #2;
    rstn_i = 1'b0;
    #1;
    check("async rst valid_o", {63'd0, valid_o}, 64'd0);
    check("async rst sig_o", {36'd0, sig_o}, 64'd0);
    check("async rst ovf_o", {62'd0, ovf_o}, 64'd0);
    check("async rst ovf_cnt_o", {56'd0, ovf_cnt_o}, 64'd0);
    valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;
    step(1'b0, 64'd0, 64'd0, 1'b0);
    step(1'b0, 64'd0, 64'd0, 1'b0);
    step(1'b1, 64'h0000_0000_0004_0000, 64'd0, 1'b0);
    check("post rst early valid", {63'd0, valid_o}, 64'd0);
    step(1'b0, 64'd0, 64'd0, 1'b0);
    check("post rst valid", {63'd0, valid_o}, 64'd1);
    check("post rst ch0", {50'd0, sig_o[13:0]}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
